hex_display_ctrl: RTL and testbench

Parametrised, registered multi-digit hexadecimal seven-segment driver for the board's HEX displays. It is the successor to the fixed two-digit output decoder. The block latches a data word on a load strobe and decodes it onto N active-low seven-segment digits. It adds per-digit enable, leading-zero suppression and per-digit blinking from an internal divider. It sits between the CPU/debug datapath and the board display pins.

---
 rtl/hex_display_ctrl.sv | 105 ++++++++++
 tb/tb_hex_display_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Registered N-digit active-low hex seven-segment driver with shadow latch,
// per-digit enable, leading-zero suppression and divider-driven blinking.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    blink_phase
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("hex_display_ctrl: NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_div
    $error("hex_display_ctrl: BLINK_DIV must be >= 1");
  end
  if ((64'd1 << CNT_W) < 64'(BLINK_DIV)) begin : g_bad_cnt_w
    $error("hex_display_ctrl: CNT_W too narrow for BLINK_DIV");
  end

  // load is a fire-and-forget strobe: there is no ready, every sampled-high
  // cycle captures data_in into the shadow register.
  logic [DW-1:0]    shadow;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase_q;
  logic [SW-1:0]    seg_q;
  logic [SW-1:0]    seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit 0 is the most significant nibble; lead_zero accumulates whether
  // every nibble from digit 0 down to the current one is zero.
  always_comb begin
    logic [3:0] nib;
    logic       lead_zero;
    logic       blank;
    seg_next  = '1;
    nib       = '0;
    lead_zero = 1'b1;
    blank     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib       = shadow[DW-1-4*i -: 4];
      lead_zero = lead_zero & (nib == 4'h0);
      blank     = !digit_en[i]
                  || (lz_blank && lead_zero && (i != NUM_DIGITS - 1))
                  || (blink_mask[i] && !phase_q);
      seg_next[7*i +: 7] = blank ? 7'h7F : hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      blink_cnt <= '0;
      phase_q   <= 1'b1;
      seg_q     <= '1;
    end else begin
      if (load) shadow <= data_in;
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        phase_q   <= ~phase_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      seg_q <= seg_next;
    end
  end

  assign seg         = seg_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised + directed bench for hex_display_ctrl; a reference model built
// from the decode table and edge counts feeds a scoreboard queue.
module tb_hex_display_ctrl;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int W   = 7 * N;

  // clock/reset block
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*N-1:0] data_in = '0;
  logic          load = 1'b0;
  logic [N-1:0]  digit_en = '1;
  logic          lz_blank = 1'b0;
  logic [N-1:0]  blink_mask = '0;
  logic [W-1:0]  seg;
  logic          blink_phase;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .blink_mask (blink_mask),
    .seg        (seg),
    .blink_phase(blink_phase)
  );

  // reference model state: shadow value and edges since reset release
  logic [6:0]  seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_shadow = '0;
  int          m_k = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ph_q[$];
  int           checks = 0;
  int           errors = 0;

  // The phase starts visible and flips once every DIV edges after reset.
  function automatic logic phase_after(input int k);
    return ((k / DIV) % 2) == 0;
  endfunction

  function automatic logic [W-1:0] model_seg(input logic [31:0] sh, input logic ph,
                                             input logic [N-1:0] en, input logic lz,
                                             input logic [N-1:0] mk);
    logic [W-1:0] r;
    logic [31:0]  upper;
    logic [3:0]   nib;
    logic         blank;
    r = '1;
    for (int i = 0; i < N; i++) begin
      upper = sh >> (4 * (N - 1 - i));
      nib   = upper[3:0];
      blank = !en[i] || (lz && (i != N - 1) && (upper == 32'd0)) || (mk[i] && !ph);
      r[7*i +: 7] = blank ? 7'h7F : seg_lut[nib];
    end
    return r;
  endfunction

  // driver: applies inputs mid-cycle and pushes what the next edge must yield
  task automatic drive(input logic r, input logic ld, input logic [31:0] d,
                       input logic [N-1:0] en, input logic lz, input logic [N-1:0] mk);
    logic [W-1:0] e;
    logic         eph;
    @(negedge clk);
    rst = r; load = ld; data_in = d; digit_en = en; lz_blank = lz; blink_mask = mk;
    if (r) begin
      e = '1;
      eph = 1'b1;
      m_shadow = '0;
      m_k = 0;
    end else begin
      e = model_seg(m_shadow, phase_after(m_k), en, lz, mk);
      if (ld) m_shadow = d;
      m_k++;
      eph = phase_after(m_k);
    end
    exp_q.push_back(e);
    exp_ph_q.push_back(eph);
  endtask

  // scoreboard monitor: one pop per clock edge once expectations exist
  initial begin
    logic [W-1:0] e;
    logic         eph;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        eph = exp_ph_q.pop_front();
        checks++;
        if (seg !== e) begin
          errors++;
          $display("FAIL seg at %0t: got %h expected %h", $time, seg, e);
        end
        checks++;
        if (blink_phase !== eph) begin
          errors++;
          $display("FAIL blink_phase at %0t: got %b expected %b", $time, blink_phase, eph);
        end
      end
    end
  end

  initial begin
    int guard;
    // reset two cycles, then release with everything enabled
    drive(1, 0, 32'h0, 8'hFF, 0, 8'h00);
    drive(1, 0, 32'h0, 8'hFF, 0, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 0, 8'h00);
    // load, then change data_in without load
    drive(0, 1, 32'h6502ABCD, 8'hFF, 0, 8'h00);
    drive(0, 0, 32'hFFFF0000, 8'hFF, 0, 8'h00);
    drive(0, 0, 32'h11111111, 8'hFF, 0, 8'h00);
    // leading-zero suppression
    drive(0, 1, 32'h000000F0, 8'hFF, 1, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 1, 8'h00);
    drive(0, 1, 32'h00000000, 8'hFF, 1, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 1, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 1, 8'h00);
    // digit 0 blinks across several phase wraps
    drive(0, 1, 32'h6502ABCD, 8'hFF, 0, 8'h01);
    for (int i = 0; i < 14; i++) drive(0, 0, 32'h0, 8'hFF, 0, 8'h01);
    // per-digit enable, then restore
    drive(0, 1, 32'h12345678, 8'h0F, 0, 8'h00);
    drive(0, 0, 32'h0, 8'h0F, 0, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 0, 8'h00);
    drive(0, 0, 32'h0, 8'hFF, 0, 8'h00);
    // reset while blink phase is 0 and shadow nonzero
    guard = 0;
    while (phase_after(m_k) && guard < 2 * DIV) begin
      drive(0, 0, 32'h0, 8'hFF, 0, 8'h01);
      guard++;
    end
    drive(0, 0, 32'h0, 8'hFF, 0, 8'h01);
    drive(1, 0, 32'h0, 8'hFF, 0, 8'h01);
    for (int i = 0; i < 10; i++) drive(0, 0, 32'h0, 8'hFF, 0, 8'h01);
    drive(0, 0, 32'h0, 8'hFF, 1, 8'h00);
    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom >> $urandom_range(0, 31);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), d,
            ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
            1'($urandom_range(0, 1)), N'($urandom));
    end
    // drain the scoreboard within a bounded number of edges
    guard = 0;
    while (exp_q.size() > 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
